// File: rtl/pipe_field.sv
// pipe_field: scrolls NUM_PIPES pipe obstacles across the playfield.
// Pipes spawn one after another at a fixed spacing. Each spawn takes its gap
// height from a free-running 8-bit LFSR. A pass pulse is produced for scoring,
// and the scroll period shortens as the level rises. Motion freezes on loss.
module pipe_field #(
  parameter int          NUM_PIPES    = 3,
  parameter int          SPAWN_X      = 1000,
  parameter int          PARK_X       = 1023,
  parameter int          SPACING      = 350,
  parameter int          BIRD_X       = 200,
  parameter int          HEIGHT_MIN   = 50,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter int          TICK_DIV     = 500000,
  parameter int          TICK_DEC     = 50000,
  parameter int          TICK_MIN     = 100000,
  parameter int          LEVEL_PASSES = 5,
  parameter int          MAX_LEVEL    = 7
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Lost,
  output logic [10*NUM_PIPES-1:0]  PipePosX,
  output logic [10*NUM_PIPES-1:0]  PipePosY,
  output logic [NUM_PIPES-1:0]     PipeActive,
  output logic                     PassPulse,
  output logic [2:0]               Level,
  output logic                     Running
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  localparam logic [9:0]  SPAWN_XV   = 10'(SPAWN_X);
  localparam logic [9:0]  PARK_XV    = 10'(PARK_X);
  localparam logic [9:0]  SPACED_XV  = 10'(SPAWN_X - SPACING);
  localparam logic [9:0]  BIRD_XV    = 10'(BIRD_X);
  localparam logic [9:0]  HMIN_V     = 10'(HEIGHT_MIN);
  localparam logic [31:0] TDIV_V     = 32'(TICK_DIV);
  localparam logic [31:0] TDEC_V     = 32'(TICK_DEC);
  localparam logic [31:0] TMIN_V     = 32'(TICK_MIN);
  localparam logic [15:0] PASS_LAST  = 16'(LEVEL_PASSES - 1);
  localparam logic [2:0]  LEVEL_TOP  = 3'(MAX_LEVEL);

  logic [1:0]            state_reg;
  logic [7:0]            lfsr_reg;
  logic [7:0]            lfsr_next;
  logic [19:0]           tick_reg;
  logic [15:0]           pass_cnt_reg;
  logic [2:0]            level_reg;
  logic                  pulse_reg;
  logic [9:0]            x_reg [NUM_PIPES];
  logic [9:0]            y_reg [NUM_PIPES];
  logic [NUM_PIPES-1:0]  active_reg;

  logic [31:0]           dec_amt;
  logic [31:0]           period;
  logic [19:0]           period_m1;
  logic                  step;
  logic                  start_run;
  logic                  to_idle;
  logic [9:0]            spawn_y;
  logic [NUM_PIPES-1:0]  pass_hit;
  logic [NUM_PIPES-1:0]  spawn;

  // Galois shift, taps x^8+x^6+x^5+x^4+1; a nonzero state never becomes zero
  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 8'hB8) : (lfsr_reg >> 1);

  // Step period shrinks with level; the floor check avoids unsigned underflow
  always_comb begin
    dec_amt = {29'd0, level_reg} * TDEC_V;
    if (dec_amt + TMIN_V >= TDIV_V) begin
      period = TMIN_V;
    end else begin
      period = TDIV_V - dec_amt;
    end
    period_m1 = 20'(period - 32'd1);
  end

  // Lost beats a pending step, so a step only fires when Lost is low
  assign step      = (state_reg == ST_RUN) && !Lost && (tick_reg == period_m1);
  assign start_run = (state_reg == ST_IDLE) && Start && !Lost;
  assign to_idle   = (state_reg == ST_FROZEN) && Start && !Lost;
  assign spawn_y   = HMIN_V + {2'b00, lfsr_reg};

  // Game state, LFSR, tick/pass counters, level and pass pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      lfsr_reg     <= LFSR_SEED;
      tick_reg     <= '0;
      pass_cnt_reg <= '0;
      level_reg    <= '0;
      pulse_reg    <= 1'b0;
    end else begin
      lfsr_reg  <= lfsr_next;
      pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_run) begin
            state_reg <= ST_RUN;
            tick_reg  <= '0;
          end
        end
        ST_RUN: begin
          if (Lost) begin
            state_reg <= ST_FROZEN;
          end else if (step) begin
            tick_reg <= '0;
            if (|pass_hit) begin
              pulse_reg <= 1'b1;
              if (pass_cnt_reg == PASS_LAST) begin
                pass_cnt_reg <= '0;
                if (level_reg != LEVEL_TOP) begin
                  level_reg <= level_reg + 3'd1;
                end
              end else begin
                pass_cnt_reg <= pass_cnt_reg + 16'd1;
              end
            end
          end else begin
            tick_reg <= tick_reg + 20'd1;
          end
        end
        ST_FROZEN: begin
          if (to_idle) begin
            state_reg    <= ST_IDLE;
            tick_reg     <= '0;
            pass_cnt_reg <= '0;
            level_reg    <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      // Pipe 0 starts with the run; later pipes trail their predecessor
      if (gi == 0) begin : g_first
        assign spawn[gi] = start_run;
      end else begin : g_rest
        assign spawn[gi] = step && !active_reg[gi] && active_reg[gi-1] &&
                           (x_reg[gi-1] == SPACED_XV);
      end

      assign pass_hit[gi] = step && active_reg[gi] && (x_reg[gi] == BIRD_XV);

      // Per-pipe position, gap height and activity
      always_ff @(posedge Clk) begin
        if (Reset || to_idle) begin
          x_reg[gi]      <= PARK_XV;
          y_reg[gi]      <= HMIN_V;
          active_reg[gi] <= 1'b0;
        end else if (spawn[gi]) begin
          x_reg[gi]      <= SPAWN_XV;
          y_reg[gi]      <= spawn_y;
          active_reg[gi] <= 1'b1;
        end else if (step && active_reg[gi]) begin
          if (x_reg[gi] == 10'd0) begin
            x_reg[gi] <= SPAWN_XV;
            y_reg[gi] <= spawn_y;
          end else begin
            x_reg[gi] <= x_reg[gi] - 10'd1;
          end
        end
      end

      assign PipePosX[10*gi +: 10] = active_reg[gi] ? x_reg[gi] : PARK_XV;
      assign PipePosY[10*gi +: 10] = y_reg[gi];
    end
  endgenerate

  assign PipeActive = active_reg;
  assign PassPulse  = pulse_reg;
  assign Level      = level_reg;
  assign Running    = (state_reg == ST_RUN);

endmodule

// File: doc/pipe_field.md
Name: pipe_field

Overview:
- Parametrised successor to the single-pipe scroller.
- Drives NUM_PIPES independent pipe obstacles across the playfield with staggered spawn and a fixed horizontal spacing.
- Each pipe gets a pseudo-random gap height from an internal LFSR instead of a fixed table.
- Emits a one-cycle pass pulse for scoring, raises scroll speed by level, and freezes on loss. It sits between the game FSM (Start/Lost) and the VGA renderer/collision logic.

Parameters:
NUM_PIPES, 3, number of pipe channels (1..8)
SPAWN_X, 1000, X loaded on spawn/respawn
PARK_X, 1023, X output while a pipe is inactive or idle
SPACING, 350, horizontal distance between consecutive pipes (< SPAWN_X)
BIRD_X, 200, X column whose crossing counts as a pass
HEIGHT_MIN, 50, minimum gap Y; HEIGHT_MIN+255 must be <= 1023
LFSR_SEED, 8'hA5, nonzero LFSR reset value
TICK_DIV, 500000, Clk cycles per 1-pixel step at level 0
TICK_DEC, 50000, cycles removed from the step period per level
TICK_MIN, 100000, floor on the step period
LEVEL_PASSES, 5, passes per level increment
MAX_LEVEL, 7, level saturation value (fits 3 bits)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  level; starts a run from IDLE, returns FROZEN to IDLE
Lost  in  1  level; collision/loss from game FSM
PipePosX  out  10*NUM_PIPES  pipe i X at bits [10i+9:10i]
PipePosY  out  10*NUM_PIPES  pipe i gap Y, same packing
PipeActive  out  NUM_PIPES  pipe i currently on field
PassPulse  out  1  one-cycle pulse per pipe crossing BIRD_X
Level  out  3  current speed level
Running  out  1  high in RUN state

Behaviour:
- Reset: synchronous and active-high. Sampled on posedge Clk; it overrides all other inputs, including mid-run.
  - State becomes IDLE.
  - All X = PARK_X, all Y = HEIGHT_MIN, PipeActive = 0.
  - LFSR = LFSR_SEED, tick counter = 0, pass counter = 0.
  - Level = 0, PassPulse = 0, Running = 0.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. Advances every Clk cycle except during Reset. It never reaches 0.
- State IDLE:
  - Outputs held at their reset values; the LFSR keeps running.
  - Start=1 and Lost=0 → RUN. On that edge: pipe 0 becomes active with X = SPAWN_X and Y = HEIGHT_MIN + LFSR; the tick counter is cleared.
- State RUN: the tick counter increments each cycle.
  - Step period P = max(TICK_DIV − Level*TICK_DEC, TICK_MIN).
  - When counter == P−1, a step occurs and the counter returns to 0.
  - On a step, each active pipe:
    - X == 0 → X = SPAWN_X and Y = HEIGHT_MIN + current LFSR (respawn); otherwise X = X − 1.
  - On a step, each inactive pipe i > 0:
    - Becomes active with X = SPAWN_X and a new Y when pipe i−1 is active and its pre-step X == SPAWN_X − SPACING.
    - Pipes activate in order and never deactivate during RUN.
    - Pipes spawning on the same step receive the same LFSR value (only possible when SPACING is pathological; accepted).
  - Pass: on a step, an active pipe with pre-step X == BIRD_X drives PassPulse = 1 on the next cycle only. Pass counter +1.
  - Level: when the pass counter reaches LEVEL_PASSES, it clears and Level increments; Level saturates at MAX_LEVEL. The new period applies from the next step.
  - Start is ignored while in RUN.
  - Lost=1 → FROZEN on the next edge. Lost has priority over a simultaneous step: that step is not taken.
- State FROZEN:
  - X, Y, PipeActive and Level are held; the tick counter is held; PassPulse = 0.
  - Start=1 and Lost=0 → IDLE, which parks all pipes and clears Level and the counters.
  - Start=1 with Lost=1 → stay in FROZEN.
- Running = 1 exactly while in RUN.
- Arithmetic widths:
  - X and Y are unsigned 10-bit; X never wraps below 0 (respawn at 0).
  - Tick counter is 20 bits; the period compare is unsigned.
- Inactive pipes always output X = PARK_X and hold their last Y.

Test Plan:
1. Reset mid-RUN (TICK_DIV=4, TICK_DEC=1, TICK_MIN=2) → next cycle: all X=1023, Y=50, PipeActive=0, Level=0, Running=0.
2. Start pulse from IDLE, NUM_PIPES=3, SPAWN_X=20, SPACING=8 → pipe0 X=20, then one decrement every 4 cycles. Pipe1 activates at X=20 on the step where pipe0 goes 12→11; pipe2 follows 8 steps later.
3. Let pipe0 reach X=0 → next step X=20 with a new Y in [50,305]; PipeActive[0] stays 1.
4. BIRD_X=15, LEVEL_PASSES=2 → PassPulse high for exactly 1 cycle after each 15→14 step. After 2 passes Level=1 and the step period becomes 3; at Level=2 the period floors at 2.
5. Assert Lost in the same cycle a step is due → X values unchanged, FROZEN. Start with Lost=1 keeps FROZEN. Start with Lost=0 → IDLE, all X=1023, Level=0.
6. Over 300 spawns, every Y satisfies 50 ≤ Y ≤ 305 and the LFSR never reads 0.
